// File: rtl/ms6205_bus_writer_if.sv
// Bundles the signals of the MS6205 bus writer that face the display controller
// (capture side: enable, address/data pair, ready) and the physical MS6205 bus
// (shared address/data lines plus the two active-low latch strobes).
interface ms6205_bus_writer_if;

   // Controller side
   logic       enable;
   logic [7:0] address_in;
   logic [7:0] data_in;
   logic       ready;

   // Physical MS6205 bus side
   logic [7:0] bus_out;
   logic       write_addr_n;
   logic       write_data_n;

   // Controller/bench view: drives the capture inputs, observes the bus
   modport master (
      output enable,
      output address_in,
      output data_in,
      input  ready,
      input  bus_out,
      input  write_addr_n,
      input  write_data_n
   );

   // Bus writer view
   modport slave (
      input  enable,
      input  address_in,
      input  data_in,
      output ready,
      output bus_out,
      output write_addr_n,
      output write_data_n
   );

endinterface

// File: rtl/ms6205_bus_writer.sv
// MS6205 bus writer: captures each new {address,data} pair from the display
// controller into a small FIFO, then replays every queued pair onto the 8-bit
// MS6205 bus as an address write followed by a data write. Each write holds the
// bus value for SETUP_W cycles before pulsing its strobe low for STROBE_W cycles.
module ms6205_bus_writer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SETUP_W    = 1,
   parameter int unsigned STROBE_W   = 1,
   localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                Clock_1ms,
   input  logic                Rst_n,
   ms6205_bus_writer_if.slave  wr_bus,
   input  logic                clr_overflow,
   output logic                busy,
   output logic                overflow,
   output logic [CntW-1:0]     fifo_count
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

   // Phase timer reload values (counter counts width-1 down to 0)
   localparam logic [2:0] SetupLd  = 3'(SETUP_W - 1);
   localparam logic [2:0] StrobeLd = 3'(STROBE_W - 1);

   localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

   // FSM encoding
   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StLoad    = 3'd1;
   localparam logic [2:0] StASetup  = 3'd2;
   localparam logic [2:0] StAStrobe = 3'd3;
   localparam logic [2:0] StDSetup  = 3'd4;
   localparam logic [2:0] StDStrobe = 3'd5;

   // FIFO storage and bookkeeping; each entry is {address, data}
   logic [15:0]     mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic [CntW-1:0] count_d;

   // Change detector shadow
   logic [15:0]     shadow_q;
   logic            valid_q;

   logic            overflow_q;

   // Replay FSM, shared phase timer and registered bus pins
   logic [2:0]      state_q;
   logic [2:0]      state_d;
   logic [2:0]      tmr_q;
   logic [2:0]      tmr_d;
   logic [7:0]      bus_q;
   logic [7:0]      bus_d;
   logic [7:0]      data_lat_q;
   logic [7:0]      data_lat_d;
   logic            wa_n_q;
   logic            wd_n_q;

   logic [15:0]     pair;
   logic            is_new;
   logic            full;
   logic            empty;
   logic            pop;
   logic            push;
   logic            drop;

   assign pair  = {wr_bus.address_in, wr_bus.data_in};
   assign full  = (count_q == FullCnt);
   assign empty = (count_q == '0);

   // LOAD is only ever entered with a non-empty FIFO, so it always pops
   assign pop = (state_q == StLoad);

   // A full FIFO still accepts a pair on the cycle its head is being popped
   assign is_new = !valid_q || (pair != shadow_q);
   assign push   = is_new && wr_bus.enable && (!full || pop);
   assign drop   = is_new && wr_bus.enable && full && !pop;

   // Occupancy next-state: simultaneous push and pop cancel
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO payload write; storage needs no reset because count_q gates every read
   always_ff @(posedge Clock_1ms) begin
      if (push) begin
         mem_q[wr_ptr_q] <= pair;
      end
   end

   // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge Clock_1ms or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   // Shadow tracks the last accepted pair; a dropped pair leaves it untouched
   // so the same pair is detected again on the next cycle
   always_ff @(posedge Clock_1ms or negedge Rst_n) begin
      if (!Rst_n) begin
         shadow_q <= '0;
         valid_q  <= 1'b0;
      end else if (push) begin
         shadow_q <= pair;
         valid_q  <= 1'b1;
      end
   end

   // Sticky drop flag; clearing wins over a same-cycle drop
   always_ff @(posedge Clock_1ms or negedge Rst_n) begin
      if (!Rst_n) begin
         overflow_q <= 1'b0;
      end else if (clr_overflow) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end
   end

   // Replay sequencing: each phase is timed by one shared down-counter that is
   // reloaded with width-1 whenever a timed phase is entered
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      bus_d      = bus_q;
      data_lat_d = data_lat_q;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            // Address goes on the bus now; data half waits in the latch
            state_d    = StASetup;
            tmr_d      = SetupLd;
            bus_d      = mem_q[rd_ptr_q][15:8];
            data_lat_d = mem_q[rd_ptr_q][7:0];
         end
         StASetup: begin
            if (tmr_q == 3'd0) begin
               state_d = StAStrobe;
               tmr_d   = StrobeLd;
            end else begin
               tmr_d = tmr_q - 3'd1;
            end
         end
         StAStrobe: begin
            if (tmr_q == 3'd0) begin
               state_d = StDSetup;
               tmr_d   = SetupLd;
               bus_d   = data_lat_q;
            end else begin
               tmr_d = tmr_q - 3'd1;
            end
         end
         StDSetup: begin
            if (tmr_q == 3'd0) begin
               state_d = StDStrobe;
               tmr_d   = StrobeLd;
            end else begin
               tmr_d = tmr_q - 3'd1;
            end
         end
         StDStrobe: begin
            if (tmr_q == 3'd0) begin
               // Back-to-back entries skip IDLE entirely
               state_d = empty ? StIdle : StLoad;
            end else begin
               tmr_d = tmr_q - 3'd1;
            end
         end
         default: begin
            state_d = StIdle;
            tmr_d   = 3'd0;
         end
      endcase
   end

   // FSM, timer, bus and strobe registers; strobes decode the next state so
   // they come straight from flops and can never be low together
   always_ff @(posedge Clock_1ms or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= StIdle;
         tmr_q      <= 3'd0;
         bus_q      <= 8'h00;
         data_lat_q <= 8'h00;
         wa_n_q     <= 1'b1;
         wd_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         bus_q      <= bus_d;
         data_lat_q <= data_lat_d;
         wa_n_q     <= (state_d != StAStrobe);
         wd_n_q     <= (state_d != StDStrobe);
      end
   end

   assign wr_bus.bus_out      = bus_q;
   assign wr_bus.write_addr_n = wa_n_q;
   assign wr_bus.write_data_n = wd_n_q;
   assign wr_bus.ready        = !full;

   assign busy       = (state_q != StIdle) || !empty;
   assign overflow   = overflow_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_ms6205_bus_writer.sv
// Bench for ms6205_bus_writer. Two instances share stimulus: one with default
// timing, one with SETUP_W=2/STROBE_W=3. A queue-based reference model predicts,
// per cycle, FIFO occupancy, flags and the bus waveform from pop times.
module tb_ms6205_bus_writer;

   localparam int Depth = 4;

   logic       Clock_1ms = 1'b0;
   logic       Rst_n     = 1'b0;
   logic       en;
   logic       clr;
   logic [7:0] a_in;
   logic [7:0] d_in;

   always #5 Clock_1ms = ~Clock_1ms;

   ms6205_bus_writer_if bus1 ();
   ms6205_bus_writer_if bus2 ();

   assign bus1.enable     = en;
   assign bus1.address_in = a_in;
   assign bus1.data_in    = d_in;
   assign bus2.enable     = en;
   assign bus2.address_in = a_in;
   assign bus2.data_in    = d_in;

   logic       busy1, ovf1, busy2, ovf2;
   logic [2:0] cnt1, cnt2;

   ms6205_bus_writer #(.FIFO_DEPTH(4), .SETUP_W(1), .STROBE_W(1)) dut (
      .Clock_1ms    (Clock_1ms),
      .Rst_n        (Rst_n),
      .wr_bus       (bus1),
      .clr_overflow (clr),
      .busy         (busy1),
      .overflow     (ovf1),
      .fifo_count   (cnt1)
   );

   ms6205_bus_writer #(.FIFO_DEPTH(4), .SETUP_W(2), .STROBE_W(3)) dut2 (
      .Clock_1ms    (Clock_1ms),
      .Rst_n        (Rst_n),
      .wr_bus       (bus2),
      .clr_overflow (clr),
      .busy         (busy2),
      .overflow     (ovf2),
      .fifo_count   (cnt2)
   );

   int n_checks, n_err;

   // Reference model state
   int          sel, ms, mw, ml;
   logic [15:0] mq[$];
   logic        sh_valid;
   logic [15:0] sh_val;
   logic        m_ovf;
   int          k, next_dec, pend_pop, pop_edge, act_start, act_end;
   logic [15:0] cur;
   logic [7:0]  last_bus;

   // Observed pins of the selected instance
   logic [7:0]  o_bus;
   logic        o_wa, o_wd, o_ready, o_busy, o_ovf;
   logic [2:0]  o_cnt;

   // Phase measurements
   int   wa_low, wd_low, wa_falls, pre_setup, last_addr, min_ready;
   logic prev_wa, mono_ok, seen_fall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
      end
   endtask

   task automatic set_par(input int s, input int w);
      ms = s;
      mw = w;
      ml = 1 + 2 * (s + w);
   endtask

   task automatic model_reset();
      mq.delete();
      sh_valid  = 1'b0;
      sh_val    = '0;
      m_ovf     = 1'b0;
      k         = 0;
      next_dec  = 1;
      pend_pop  = -1000;
      pop_edge  = -1000;
      act_start = -1000;
      act_end   = -1000;
      cur       = '0;
      last_bus  = 8'h00;
      prev_wa   = 1'b1;
   endtask

   task automatic clr_meas();
      wa_low    = 0;
      wd_low    = 0;
      wa_falls  = 0;
      pre_setup = 0;
      last_addr = -1;
      min_ready = 1;
      mono_ok   = 1'b1;
      seen_fall = 1'b0;
   endtask

   task automatic sample();
      if (sel == 1) begin
         o_bus = bus1.bus_out; o_wa = bus1.write_addr_n; o_wd = bus1.write_data_n;
         o_ready = bus1.ready; o_busy = busy1; o_ovf = ovf1; o_cnt = cnt1;
      end else begin
         o_bus = bus2.bus_out; o_wa = bus2.write_addr_n; o_wd = bus2.write_data_n;
         o_ready = bus2.ready; o_busy = busy2; o_ovf = ovf2; o_cnt = cnt2;
      end
   endtask

   task automatic check_reset_vals(input string pfx);
      sample();
      chk({pfx, "_bus"}, 32'(o_bus), 32'h00);
      chk({pfx, "_wa"}, 32'(o_wa), 32'd1);
      chk({pfx, "_wd"}, 32'(o_wd), 32'd1);
      chk({pfx, "_ready"}, 32'(o_ready), 32'd1);
      chk({pfx, "_busy"}, 32'(o_busy), 32'd0);
      chk({pfx, "_ovf"}, 32'(o_ovf), 32'd0);
      chk({pfx, "_cnt"}, 32'(o_cnt), 32'd0);
   endtask

   // Holds reset for two edges, releases on a falling edge, checks idle outputs
   task automatic apply_reset();
      Rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge Clock_1ms);
      @(negedge Clock_1ms);
      Rst_n = 1'b1;
      #1;
      check_reset_vals("post_rst");
   endtask

   // One clock edge: advance the model with the current inputs, then compare
   task automatic tick();
      logic [15:0] pr;
      logic        nw, mfull, popm, pushm, dropm, e_wa, e_wd, e_busy;
      int          o;
      k++;
      pr = {a_in, d_in};
      // Writer looks at the queue on a decision edge; a pop follows one edge
      // later and the next decision comes one full write duration after that
      if (k == next_dec) begin
         if (mq.size() > 0) begin
            pend_pop  = k + 1;
            next_dec  = k + ml;
            act_start = k;
            act_end   = k + ml - 1;
         end else begin
            next_dec = k + 1;
         end
      end
      popm  = (k == pend_pop);
      nw    = !sh_valid || (pr != sh_val);
      mfull = (mq.size() == Depth);
      pushm = nw && en && (!mfull || popm);
      dropm = nw && en && mfull && !popm;
      if (clr) m_ovf = 1'b0;
      else if (dropm) m_ovf = 1'b1;
      if (popm) begin
         cur      = mq.pop_front();
         pop_edge = k;
      end
      if (pushm) begin
         mq.push_back(pr);
         sh_valid = 1'b1;
         sh_val   = pr;
      end
      e_wa = 1'b1;
      e_wd = 1'b1;
      if (k >= pop_edge && k <= pop_edge + ml - 2) begin
         o        = k - pop_edge;
         last_bus = (o < ms + mw) ? cur[15:8] : cur[7:0];
         e_wa     = !(o >= ms && o < ms + mw);
         e_wd     = !(o >= 2 * ms + mw);
      end
      e_busy = (k >= act_start && k <= act_end) || (mq.size() > 0);

      @(posedge Clock_1ms);
      #1;
      sample();
      chk("bus_out", 32'(o_bus), 32'(last_bus));
      chk("write_addr_n", 32'(o_wa), 32'(e_wa));
      chk("write_data_n", 32'(o_wd), 32'(e_wd));
      chk("ready", 32'(o_ready), 32'(mq.size() != Depth));
      chk("busy", 32'(o_busy), 32'(e_busy));
      chk("overflow", 32'(o_ovf), 32'(m_ovf));
      chk("fifo_count", 32'(o_cnt), 32'(mq.size()));

      wa_low += (o_wa === 1'b0) ? 1 : 0;
      wd_low += (o_wd === 1'b0) ? 1 : 0;
      if (!o_ready) min_ready = 0;
      if (!seen_fall && o_wa && o_bus == a_in) pre_setup++;
      if (prev_wa && !o_wa) begin
         wa_falls++;
         seen_fall = 1'b1;
         if (int'(o_bus) <= last_addr) mono_ok = 1'b0;
         last_addr = int'(o_bus);
      end
      prev_wa = o_wa;
   endtask

   initial begin
      logic found;
      n_checks = 0;
      n_err    = 0;
      en = 1'b0; clr = 1'b0; a_in = 8'h00; d_in = 8'h00;
      sel = 1;
      set_par(1, 1);
      model_reset();
      clr_meas();

      // Reset state while held in reset
      #12;
      check_reset_vals("in_rst");
      @(negedge Clock_1ms);
      Rst_n = 1'b1;

      // Single write of 05/41
      en = 1'b1; a_in = 8'h05; d_in = 8'h41;
      clr_meas();
      repeat (10) tick();
      chk("single_wa_cycles", 32'(wa_low), 32'd1);
      chk("single_wd_cycles", 32'(wd_low), 32'd1);
      chk("single_busy_end", 32'(o_busy), 32'd0);

      // Same pair held: no further writes
      repeat (50) tick();
      chk("hold_write_count", 32'(wa_falls), 32'd1);
      chk("hold_fifo_empty", 32'(o_cnt), 32'd0);

      // Overflow: new address every cycle
      clr_meas();
      d_in = 8'h30;
      for (int i = 0; i < 24; i++) begin
         a_in = 8'(i);
         tick();
      end
      chk("ovf_ready_dropped", 32'(min_ready), 32'd0);
      chk("ovf_flag_set", 32'(o_ovf), 32'd1);
      repeat (30) tick();
      chk("ovf_drain_increasing", 32'(mono_ok), 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("ovf_cleared", 32'(o_ovf), 32'd0);

      // Full FIFO with a new pair arriving on the pop cycle
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         clr = 1'b0;
         if (mq.size() == Depth && pend_pop == k + 1 && !m_ovf) begin
            found = 1'b1;
            a_in  = a_in + 8'd1;
            tick();
            chk("fullpop_overflow", 32'(o_ovf), 32'd0);
            chk("fullpop_count", 32'(o_cnt), 32'(Depth));
         end else begin
            if (mq.size() < Depth) a_in = a_in + 8'd1;
            else clr = m_ovf;
            tick();
         end
      end
      clr = 1'b0;
      chk("fullpop_reached", 32'(found), 32'd1);

      // Randomized traffic over a small value set so repeats occur
      for (int i = 0; i < 300; i++) begin
         en  = ($urandom_range(0, 7) != 0);
         clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 2) == 0) begin
            a_in = 8'($urandom_range(0, 3));
            d_in = 8'($urandom_range(0, 1));
         end
         tick();
      end
      en = 1'b1; clr = 1'b0;
      repeat (30) tick();

      // Second instance: SETUP_W=2, STROBE_W=3
      sel = 2;
      set_par(2, 3);
      a_in = 8'hA5; d_in = 8'h5A;
      apply_reset();
      clr_meas();
      repeat (20) tick();
      chk("p2_wa_cycles", 32'(wa_low), 32'd3);
      chk("p2_wd_cycles", 32'(wd_low), 32'd3);
      chk("p2_addr_setup", 32'(pre_setup), 32'd2);
      chk("p2_write_count", 32'(wa_falls), 32'd1);
      for (int i = 0; i < 150; i++) begin
         en  = ($urandom_range(0, 5) != 0);
         clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) begin
            a_in = 8'($urandom_range(0, 255));
            d_in = 8'($urandom_range(0, 255));
         end
         tick();
      end
      en = 1'b1; clr = 1'b0;
      repeat (60) tick();

      // Reset asserted during A_STROBE
      sel = 1;
      set_par(1, 1);
      a_in = 8'h77; d_in = 8'h12;
      apply_reset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (k == pop_edge + ms) found = 1'b1;
      end
      chk("rst_in_astrobe", 32'(o_wa), 32'd0);
      #2;
      Rst_n = 1'b0;
      #1;
      sample();
      chk("rst_async_wa_high", 32'(o_wa), 32'd1);
      check_reset_vals("mid_rst");
      model_reset();
      @(negedge Clock_1ms);
      Rst_n = 1'b1;
      #1;
      check_reset_vals("rel_rst");
      clr_meas();
      repeat (15) tick();
      chk("rst_rewrite_once", 32'(wa_falls), 32'd1);
      chk("rst_rewrite_addr", 32'(last_addr), 32'h77);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ms6205_bus_writer.md
# ms6205_bus_writer

Downstream stage of the MS6205 display controller. It samples the controller's `address`/`data` pair every `Clock_1ms` tick and queues each new pair in a small FIFO. It then replays each queued pair onto the physical MS6205 8-bit bus as an address write followed by a data write, each with programmable setup and strobe widths. It also returns a `ready` back-pressure indication to the controller and flags dropped writes.

## Interface
- `FIFO_DEPTH`, 4: number of queued {address,data} pairs; power of two, 2..16.
- `SETUP_W`, 1: cycles the bus value is held stable before each strobe; 1..7.
- `STROBE_W`, 1: cycles each strobe is held low; 1..7.

- `Clock_1ms` in 1: system tick; all logic on rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: capture enable; 0 suppresses new pushes; queued entries still drain.
- `address_in` in 8: cell address from the display controller.
- `data_in` in 8: symbol code from the display controller.
- `clr_overflow` in 1: synchronous clear of `overflow`.
- `bus_out` out 8: MS6205 shared address/data bus.
- `write_addr_n` out 1: active-low address latch strobe.
- `write_data_n` out 1: active-low data latch strobe.
- `ready` out 1: FIFO not full; routed to the controller's `ready` input.
- `busy` out 1: FSM not in IDLE, or FIFO non-empty.
- `overflow` out 1: sticky; set when a new pair is dropped.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- Change detector:
  - A shadow register holds the last pushed {address,data} plus a `valid` bit.
  - After reset, `valid` is 0, so the first sample with `enable`=1 always counts as new.
  - A pair is new when `valid`=0 or it differs from the shadow in any bit.
  - The shadow updates only on a successful push.
- Push: occurs when the pair is new, `enable`=1, and the FIFO is not full (or is full and a pop happens in the same cycle).
- Drop: a new pair that arrives while the FIFO is full with no pop is dropped. `overflow` is set, the shadow is not updated, and the pair is re-detected next cycle if still present.
- FIFO: circular buffer. Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves `fifo_count` unchanged.
- FSM states: IDLE, LOAD, A_SETUP, A_STROBE, D_SETUP, D_STROBE.
  - IDLE: if the FIFO is non-empty, go to LOAD.
  - LOAD: pop the head into the working latch, drive `bus_out`=addr, go to A_SETUP.
  - A_SETUP: hold addr for SETUP_W cycles, then go to A_STROBE.
  - A_STROBE: `write_addr_n`=0 for STROBE_W cycles; `bus_out` stays addr; then go to D_SETUP.
  - D_SETUP: `bus_out`=data, both strobes high, for SETUP_W cycles; then go to D_STROBE.
  - D_STROBE: `write_data_n`=0 for STROBE_W cycles; then go to LOAD if the FIFO is non-empty, else IDLE.
- One shared 3-bit down-counter times every phase. It is loaded with width−1 on phase entry.
- The two strobes are never low together. `bus_out` changes only in LOAD and on D_SETUP entry.
- `bus_out` keeps its last value in IDLE.
- `overflow`: `clr_overflow` has priority over a same-cycle set.

## Timing
- Reset values: `bus_out`=8'h00, `write_addr_n`=1, `write_data_n`=1, `ready`=1, `busy`=0, `overflow`=0, `fifo_count`=0, FSM=IDLE, shadow `valid`=0.
- Capture latency: a pair is sampled at edge N, written to the FIFO at edge N, and visible in `fifo_count` after edge N.
- Start latency: IDLE→LOAD at edge N+1, so `bus_out`=addr after edge N+2.
- Write duration per entry: 1 + 2·(SETUP_W+STROBE_W) cycles; 5 cycles with default parameters.
- Back-to-back entries go D_STROBE→LOAD with no IDLE gap.
- `ready` and `fifo_count` are registered-consistent: both reflect the state after the current edge.
- Asynchronous reset mid-write:
  - Strobes return high immediately.
  - The FIFO empties and the in-flight entry is discarded.
  - After release, nothing is written until a new pair is detected.

## Test plan
- Single write: reset, then hold address_in=8'h05, data_in=8'h41 → exactly one sequence with `bus_out`=05, `write_addr_n` low 1 cycle, then `bus_out`=41, `write_data_n` low 1 cycle; 5 cycles total; then IDLE with `busy`=0.
- Unchanged input: hold the same pair for 50 cycles → only one write sequence; `fifo_count` returns to 0.
- Overflow: change address_in every cycle 00,01,02,… with FIFO_DEPTH=4 → `ready` drops to 0; `overflow`=1; the pairs drained to the bus are strictly increasing; `clr_overflow` pulse returns `overflow` to 0.
- Full plus same-cycle pop: FIFO full, a new pair arrives on the LOAD cycle → pair accepted, `overflow` stays 0, `fifo_count` stays 4.
- Parameters SETUP_W=2, STROBE_W=3: `write_addr_n` low exactly 3 cycles, preceded by 2 stable-addr cycles; total 11 cycles; strobes never overlap.
- Reset during A_STROBE: `write_addr_n` rises asynchronously; after release, all outputs equal reset values, and the same held input pair is re-written once.
